// File: rtl/vif_handshake_fifo.sv
// Elastic valid/ready FIFO between two handshake channels, with a sticky producer-protocol monitor.
// Optional zero-latency empty-FIFO bypass is enabled by defining VIF_FIFO_BYPASS_EN.
module vif_handshake_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              proto_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              proto_err_q, proto_err_d;
    logic              stall_q, stall_d;
    logic [DATA_W-1:0] stall_data_q, stall_data_d;

    logic stored_valid;
    logic bypass;
    logic bypass_xfer;
    logic push;
    logic pop;
    logic stall;
    logic violation;

    // in_ready is a function of state (and reset) only, so it never loops back through out_ready.
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign in_ready     = !full && !rst;
    assign stored_valid = !empty;

`ifdef VIF_FIFO_BYPASS_EN
    assign bypass = empty && in_valid && !rst;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that is taken immediately never touches storage.
    assign bypass_xfer = bypass && out_ready;
    assign push        = in_valid && in_ready && !bypass_xfer;
    assign pop         = stored_valid && out_ready;

    assign out_valid = stored_valid || bypass;

    always_comb begin
        out_data = '0;
        if (stored_valid) begin
            out_data = mem[rd_ptr_q];
        end else if (bypass) begin
            out_data = in_data;
        end
    end

    assign count     = count_q;
    assign proto_err = proto_err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // A stalled producer must keep valid high and data stable until accepted.
    assign stall        = in_valid && !in_ready;
    assign violation    = stall_q && (!in_valid || (in_data != stall_data_q));
    assign stall_d      = stall;
    assign stall_data_d = in_data;
    assign proto_err_d  = proto_err_q || violation;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            proto_err_q  <= 1'b0;
            stall_q      <= 1'b0;
            stall_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            proto_err_q  <= proto_err_d;
            stall_q      <= stall_d;
            stall_data_q <= stall_data_d;
        end
    end

    // Storage is deliberately left out of reset; push is already gated off while rst is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_vif_handshake_fifo.sv
// Scoreboard bench for vif_handshake_fifo (DATA_W=8, DEPTH=4); driver queues expected words, monitor checks pops.
module tb_vif_handshake_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    vif_handshake_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accepted words go to the scoreboard in the order the FIFO must return them.
    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        if (v && in_ready && !rst) begin
            exp_q.push_back(d);
            $display("push %02h (queue depth %0d)", d, exp_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %02h, required no output", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pop_data: got %02h, required %02h", out_data, mon_exp);
                end else begin
                    $display("pop  %02h", out_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        tick;
        tick;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        rst = 1'b0;
        #1;
        check("release_in_ready", in_ready, 1);

        // Fill with consumer blocked, then drain.
        drive(1, 8'h11, 0); tick;
        check("first_push_count", count, 1);
        check("first_push_out_valid", out_valid, 1);
        check("first_push_out_data", out_data, 8'h11);
        drive(1, 8'h22, 0); tick;
        drive(1, 8'h33, 0); tick;
        drive(1, 8'h44, 0); tick;
        check("fill_count", count, 4);
        check("fill_full", full, 1);
        check("fill_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'h00, 1); tick;
        end
        check("drain_empty", empty, 1);
        check("drain_out_valid", out_valid, 0);
        check("drain_out_data", out_data, 0);

        // Continuous streaming across several pointer wraps.
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'(i), 1); tick;
`ifdef VIF_FIFO_BYPASS_EN
            check("stream_count", count, 0);
`else
            check("stream_count", count, 1);
`endif
        end
        drive(0, 8'h00, 1); tick;
        check("stream_end_empty", empty, 1);

        // Full FIFO with a simultaneous pop: no push that cycle.
        drive(1, 8'h01, 0); tick;
        drive(1, 8'h02, 0); tick;
        drive(1, 8'h03, 0); tick;
        drive(1, 8'h04, 0); tick;
        check("fp_full", full, 1);
        drive(1, 8'h55, 1);
        check("fp_cycle0_in_ready", in_ready, 0);
        tick;
        check("fp_cycle0_count", count, 3);
        check("fp_cycle1_in_ready", in_ready, 1);
        drive(1, 8'h55, 0); tick;
        check("fp_cycle1_count", count, 4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'h00, 1); tick;
        end
        check("fp_drain_empty", empty, 1);
        check("legal_stall_proto_err", proto_err, 0);

        // Producer changes data while stalled.
        drive(1, 8'hB1, 0); tick;
        drive(1, 8'hB2, 0); tick;
        drive(1, 8'hB3, 0); tick;
        drive(1, 8'hB4, 0); tick;
        drive(1, 8'hA5, 0); tick;
        check("stall_proto_err", proto_err, 0);
        drive(1, 8'hA6, 0); tick;
        check("viol_proto_err", proto_err, 1);
        drive(0, 8'h00, 0); tick;
        check("viol_sticky", proto_err, 1);
        check("viol_count", count, 4);
        drive(0, 8'h00, 1); tick;
        drive(0, 8'h00, 0);
        check("pre_rst_count", count, 3);

        // Asynchronous reset mid-cycle discards contents.
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_proto_err", proto_err, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_count", count, 0);

        // Push into empty FIFO with consumer ready.
        drive(1, 8'h7E, 1);
        #1;
`ifdef VIF_FIFO_BYPASS_EN
        check("byp_out_valid", out_valid, 1);
        check("byp_out_data", out_data, 8'h7E);
        tick;
        drive(0, 8'h00, 1);
        check("byp_count", count, 0);
        check("byp_next_out_valid", out_valid, 0);
`else
        check("nobyp_out_valid", out_valid, 0);
        tick;
        drive(0, 8'h00, 1);
        check("nobyp_count", count, 1);
        check("nobyp_next_out_valid", out_valid, 1);
        check("nobyp_next_out_data", out_data, 8'h7E);
`endif
        tick;
        drive(0, 8'h00, 0);
        tick;
        check("final_empty", empty, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
